// File: rtl/roll_over_pkg.sv
// roll_over_pkg: shared types and constants for the roll-over prescaler.
package roll_over_pkg;

    // S_DONE is only reachable when ROLL_OVER_ONESHOT_EN is defined.
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PEND,
        S_DONE
    } state_t;

    // Smallest usable limit; a limit of 0 would hold o_roll_over high.
    localparam int unsigned MIN_LIMIT = 1;

endpackage : roll_over_pkg

// File: rtl/roll_over_gen.sv
// roll_over_gen: programmable prescaler producing a one-cycle, registered
// roll-over strobe every (limit+1) enabled cycles. New limits arrive through a
// valid/ready handshake and take effect only at a wrap, or immediately when idle.
// Optional macro ROLL_OVER_ONESHOT_EN adds i_oneshot: stop after the first
// pulse until i_enable has been seen low.
module roll_over_gen
    import roll_over_pkg::*;
#(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned DEFAULT_LIMIT = 49999
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
`ifdef ROLL_OVER_ONESHOT_EN
    input  logic             i_oneshot,
`endif
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_limit_valid,
    output logic             o_limit_ready,
    output logic             o_roll_over,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] LIMIT_RST = WIDTH'(DEFAULT_LIMIT);
    localparam logic [WIDTH-1:0] LIMIT_MIN = WIDTH'(MIN_LIMIT);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] m_count, count_nxt;
    logic [WIDTH-1:0] m_limit, limit_nxt;
    logic [WIDTH-1:0] m_limit_pend, pend_nxt;
    logic             roll_nxt;
    logic [WIDTH-1:0] limit_in;
    logic             accept;
    logic             at_wrap;

    assign limit_in = (i_limit == '0) ? LIMIT_MIN : i_limit;
    assign accept   = i_limit_valid & o_limit_ready;
    // >= rather than == so a count left above a limit applied on disable
    // still wraps at the next enabled edge instead of running to overflow.
    assign at_wrap  = (m_count >= m_limit);
    assign o_count  = m_count;

    // State, counter, limit registers and the registered roll-over pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_IDLE;
            m_count      <= '0;
            m_limit      <= LIMIT_RST;
            m_limit_pend <= LIMIT_RST;
            o_roll_over  <= 1'b0;
        end else begin
            state        <= state_nxt;
            m_count      <= count_nxt;
            m_limit      <= limit_nxt;
            m_limit_pend <= pend_nxt;
            o_roll_over  <= roll_nxt;
        end
    end

    // Next-state, counting, limit handoff and handshake ready.
    always_comb begin
        state_nxt     = state;
        count_nxt     = m_count;
        limit_nxt     = m_limit;
        pend_nxt      = m_limit_pend;
        roll_nxt      = 1'b0;
        o_limit_ready = (state != S_PEND);

        case (state)
            S_RUN: begin
                if (!i_enable) begin
                    state_nxt = S_IDLE;
                    if (accept) limit_nxt = limit_in;
                end else begin
                    if (at_wrap) begin
                        count_nxt = '0;
                        roll_nxt  = 1'b1;
                    end else begin
                        count_nxt = m_count + 1'b1;
                    end
                    // A limit accepted on a wrap edge waits for the following wrap.
                    if (accept) begin
                        pend_nxt  = limit_in;
                        state_nxt = S_PEND;
                    end
`ifdef ROLL_OVER_ONESHOT_EN
                    if (at_wrap && i_oneshot) begin
                        state_nxt = S_DONE;
                        if (accept) limit_nxt = limit_in;
                    end
`endif
                end
            end

            S_PEND: begin
                if (!i_enable) begin
                    state_nxt = S_IDLE;
                    limit_nxt = m_limit_pend;
                end else if (at_wrap) begin
                    count_nxt = '0;
                    roll_nxt  = 1'b1;
                    limit_nxt = m_limit_pend;
                    state_nxt = S_RUN;
`ifdef ROLL_OVER_ONESHOT_EN
                    if (i_oneshot) state_nxt = S_DONE;
`endif
                end else begin
                    count_nxt = m_count + 1'b1;
                end
            end

`ifdef ROLL_OVER_ONESHOT_EN
            S_DONE: begin
                if (accept) begin
                    limit_nxt = limit_in;
                    count_nxt = '0;
                end
                if (!i_enable) state_nxt = S_IDLE;
            end
`endif

            default: begin
                if (accept) begin
                    limit_nxt = limit_in;
                    count_nxt = '0;
                end
                if (i_enable) state_nxt = S_RUN;
            end
        endcase
    end

endmodule : roll_over_gen

// File: tb/tb_roll_over_gen.sv
// tb_roll_over_gen: scoreboard bench for roll_over_gen (default build).
// Stimulus steps a behavioural model and queues the expected post-edge outputs;
// a monitor pops and compares them one cycle later.
module tb_roll_over_gen;

    localparam int unsigned W   = 8;
    localparam int unsigned DEF = 4;

    logic         clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic         i_enable = 1'b0;
    logic [W-1:0] i_limit = '0;
    logic         i_limit_valid = 1'b0;
    logic         o_limit_ready;
    logic         o_roll_over;
    logic [W-1:0] o_count;

    roll_over_gen #(
        .WIDTH         (W),
        .DEFAULT_LIMIT (DEF)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_enable      (i_enable),
        .i_limit       (i_limit),
        .i_limit_valid (i_limit_valid),
        .o_limit_ready (o_limit_ready),
        .o_roll_over   (o_roll_over),
        .o_count       (o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit roll;
        int cnt;
        bit rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: counting flag, count, active limit, pending-limit queue.
    bit   running = 0;
    int   cnt = 0;
    int   lim = DEF;
    int   pend_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        running = 0;
        cnt     = 0;
        lim     = DEF;
        pend_q.delete();
    endfunction

    // One clock edge of the specified behaviour; queues the expected result.
    function automatic void model_step(input bit en, input bit vld, input int lv);
        bit   acc;
        int   v;
        exp_t e;
        acc    = vld && (pend_q.size() == 0);
        v      = (lv == 0) ? 1 : lv;
        e.roll = 0;
        if (!running) begin
            if (acc) begin
                lim = v;
                cnt = 0;
            end
            running = en;
        end else if (!en) begin
            running = 0;
            if (pend_q.size() != 0) lim = pend_q.pop_front();
            else if (acc) lim = v;
        end else begin
            if (cnt >= lim) begin
                cnt    = 0;
                e.roll = 1;
                if (pend_q.size() != 0) lim = pend_q.pop_front();
            end else begin
                cnt++;
            end
            if (acc) pend_q.push_back(v);
        end
        e.cnt = cnt;
        e.rdy = (pend_q.size() == 0);
        exp_q.push_back(e);
    endfunction

    task automatic step(input bit en, input bit vld, input int lv);
        @(negedge clk);
        i_enable      = en;
        i_limit_valid = vld;
        i_limit       = W'(lv);
        model_step(en, vld, lv);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0);
    endtask

    task automatic run_until_cnt(input int t);
        for (int i = 0; i < 64 && cnt != t; i++) step(1, 0, 0);
    endtask

    task automatic run_until_wrap();
        for (int i = 0; i < 64 && cnt < lim; i++) step(1, 0, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        i_reset_n     = 1'b0;
        i_enable      = 1'b0;
        i_limit_valid = 1'b0;
        #1;
        chk("rst_count", int'(o_count), 0);
        chk("rst_roll", int'(o_roll_over), 0);
        chk("rst_ready", int'(o_limit_ready), 1);
        @(negedge clk);
        @(negedge clk);
        i_reset_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compare each queued expectation just after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("roll_over", int'(o_roll_over), int'(e.roll));
                chk("count", int'(o_count), e.cnt);
                chk("limit_ready", int'(o_limit_ready), int'(e.rdy));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Default limit 4, continuous counting.
        run(20);

        // Push 9 at count 2: current period completes, then periods of 10.
        run_until_cnt(2);
        step(1, 1, 9);
        run(30);

        // Restore 4, then push 2 on a wrap cycle: one more 5-period, then 3.
        step(1, 1, 4);
        run(25);
        run_until_wrap();
        step(1, 1, 2);
        run(15);

        // Disable at count 3, load 7 while idle, re-enable from 0.
        do_reset();
        step(1, 0, 0);
        run_until_cnt(3);
        step(0, 0, 0);
        step(0, 1, 7);
        step(1, 0, 0);
        run(20);

        // Limit 0 clamps to 1, both via pending and idle paths.
        step(1, 1, 0);
        run(12);
        step(0, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        run(8);

        // Reset while a limit is pending at count 3, then default period.
        do_reset();
        step(1, 0, 0);
        run_until_cnt(2);
        step(1, 1, 9);
        run_until_cnt(3);
        do_reset();
        step(1, 0, 0);
        run(12);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
                     int'($urandom_range(0, 12)));
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_roll_over_gen
